// File: rtl/transiciones_pkg.sv
// Shared defaults and helpers for the multichannel transition counter.
// Channel indices match the adders under test (ripple, logic, look-ahead).
package transiciones_pkg;

  localparam int NCANALES_DEF = 3;
  localparam int ANCHO_DEF    = 8;
  localparam int CNT_W_DEF    = 32;
  localparam int DIR_W_DEF    = 2;

  localparam int CANAL_RIZADO    = 0;
  localparam int CANAL_LOGICO    = 1;
  localparam int CANAL_LOOKAHEAD = 2;

  function automatic int pop_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int POP_W = pop_w(ANCHO_DEF);

endpackage

// File: rtl/contador_unos.sv
// Combinational popcount of an ANCHO-bit vector.
// Result width is just enough to hold ANCHO.
module contador_unos
  import transiciones_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic [ANCHO-1:0]        vec,
  output logic [pop_w(ANCHO)-1:0] unos
);

  localparam int PW = pop_w(ANCHO);

  always_comb begin
    unos = '0;
    for (int i = 0; i < ANCHO; i++) begin
      unos = unos + PW'(vec[i]);
    end
  end

endmodule

// File: rtl/contador_transiciones_multicanal.sv
// Per-channel bit-toggle counters with addressed read/preset port.
// Optional peak-toggle output enabled by macro PICO_TRANSICIONES_EN.
module contador_transiciones_multicanal
  import transiciones_pkg::*;
#(
  parameter int NCANALES = NCANALES_DEF,
  parameter int ANCHO    = ANCHO_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DIR_W    = DIR_W_DEF,
  parameter int SATURAR  = 1
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      habilitar,
  input  logic [NCANALES*ANCHO-1:0] muestras,
  input  logic [DIR_W-1:0]          dir,
  input  logic                      LE,
  input  logic                      escr,
  input  logic [CNT_W-1:0]          dato_in,
  output logic [CNT_W-1:0]          dato_out,
  output logic                      dato_valido,
  output logic [NCANALES-1:0]       desborde
`ifdef PICO_TRANSICIONES_EN
  ,
  output logic [NCANALES*pop_w(ANCHO)-1:0] pico
`endif
);

  localparam int PW = pop_w(ANCHO);

  logic             ref_ok;
  logic [CNT_W-1:0] cnt [NCANALES];
  logic [CNT_W-1:0] lectura;

  for (genvar k = 0; k < NCANALES; k++) begin : g_canal
    logic [ANCHO-1:0] muestra;
    logic [ANCHO-1:0] ref_q;
    logic [PW-1:0]    inc;
    logic [CNT_W:0]   suma;
    logic [CNT_W-1:0] cnt_q;
    logic             des_q;
    logic             esc_k;
    logic             cuenta;

    assign muestra = muestras[k*ANCHO +: ANCHO];
    assign esc_k   = escr && !LE && (dir == DIR_W'(k));
    assign cuenta  = habilitar && ref_ok;
    assign suma    = {1'b0, cnt_q} + (CNT_W+1)'(inc);

    contador_unos #(
      .ANCHO(ANCHO)
    ) u_unos (
      .vec (muestra ^ ref_q),
      .unos(inc)
    );

    // A preset on this channel takes priority over its own increment.
    always_ff @(posedge clk) begin
      if (!reset_L) begin
        cnt_q <= '0;
        des_q <= 1'b0;
        ref_q <= '0;
      end else begin
        if (habilitar) begin
          ref_q <= muestra;
        end
        if (esc_k) begin
          cnt_q <= dato_in;
          des_q <= 1'b0;
        end else if (cuenta) begin
          if (suma[CNT_W]) begin
            cnt_q <= (SATURAR != 0) ? {CNT_W{1'b1}}
                                    : suma[CNT_W-1:0];
            des_q <= 1'b1;
          end else begin
            cnt_q <= suma[CNT_W-1:0];
          end
        end
      end
    end

    assign cnt[k]      = cnt_q;
    assign desborde[k] = des_q;

`ifdef PICO_TRANSICIONES_EN
    logic [PW-1:0] pico_q;

    always_ff @(posedge clk) begin
      if (!reset_L) begin
        pico_q <= '0;
      end else if (esc_k) begin
        pico_q <= '0;
      end else if (cuenta && (inc > pico_q)) begin
        pico_q <= inc;
      end
    end

    assign pico[k*PW +: PW] = pico_q;
`endif
  end

  // Unmapped addresses fall through to zero.
  always_comb begin
    lectura = '0;
    for (int i = 0; i < NCANALES; i++) begin
      if (dir == DIR_W'(i)) begin
        lectura = cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      ref_ok      <= 1'b0;
      dato_out    <= '0;
      dato_valido <= 1'b0;
    end else begin
      ref_ok      <= habilitar;
      dato_valido <= LE;
      if (LE) begin
        dato_out <= lectura;
      end
    end
  end

endmodule

// File: tb/tb_contador_transiciones_multicanal.sv
// Bench: three instances (32-bit, 4-bit saturating, 4-bit wrapping)
// share stimulus; checked against vectors, hand sequences and a model.
module tb_contador_transiciones_multicanal;
  import transiciones_pkg::*;

  localparam int NC = 3;
  localparam int AN = 8;
  localparam int PW = pop_w(AN);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_L;
  logic             habilitar;
  logic [NC*AN-1:0] muestras;
  logic [1:0]       dir;
  logic             LE;
  logic             escr;
  logic [31:0]      dato_in;

  logic [31:0] dout0;
  logic [3:0]  dout1, dout2;
  logic        dv0, dv1, dv2;
  logic [2:0]  des0, des1, des2;
`ifdef PICO_TRANSICIONES_EN
  logic [NC*PW-1:0] pico0, pico1, pico2;
`endif

  contador_transiciones_multicanal dut (
    .clk(clk), .reset_L(reset_L), .habilitar(habilitar),
    .muestras(muestras), .dir(dir), .LE(LE), .escr(escr),
    .dato_in(dato_in), .dato_out(dout0), .dato_valido(dv0),
    .desborde(des0)
`ifdef PICO_TRANSICIONES_EN
    , .pico(pico0)
`endif
  );

  contador_transiciones_multicanal #(
    .CNT_W(4), .SATURAR(1)
  ) dut_sat (
    .clk(clk), .reset_L(reset_L), .habilitar(habilitar),
    .muestras(muestras), .dir(dir), .LE(LE), .escr(escr),
    .dato_in(dato_in[3:0]), .dato_out(dout1), .dato_valido(dv1),
    .desborde(des1)
`ifdef PICO_TRANSICIONES_EN
    , .pico(pico1)
`endif
  );

  contador_transiciones_multicanal #(
    .CNT_W(4), .SATURAR(0)
  ) dut_wrap (
    .clk(clk), .reset_L(reset_L), .habilitar(habilitar),
    .muestras(muestras), .dir(dir), .LE(LE), .escr(escr),
    .dato_in(dato_in[3:0]), .dato_out(dout2), .dato_valido(dv2),
    .desborde(des2)
`ifdef PICO_TRANSICIONES_EN
    , .pico(pico2)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: counters as plain integers, one row per config.
  int      cw[3]   = '{32, 4, 4};
  bit      csat[3] = '{1'b1, 1'b1, 1'b0};
  longint  m_cnt[3][NC];
  bit      m_des[3][NC];
  longint  m_dout[3];
  bit      m_dv;
  bit [AN-1:0] m_ref[NC];
  bit      m_ok;
  int      m_pico[NC];

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic void model_step();
    if (!reset_L) begin
      for (int c = 0; c < 3; c++) begin
        m_dout[c] = 0;
        for (int k = 0; k < NC; k++) begin
          m_cnt[c][k] = 0;
          m_des[c][k] = 1'b0;
        end
      end
      for (int k = 0; k < NC; k++) begin
        m_ref[k]  = '0;
        m_pico[k] = 0;
      end
      m_dv = 1'b0;
      m_ok = 1'b0;
      return;
    end
    for (int c = 0; c < 3; c++) begin
      if (LE) m_dout[c] = (dir < NC) ? m_cnt[c][dir] : 0;
    end
    m_dv = LE;
    for (int k = 0; k < NC; k++) begin
      bit [AN-1:0] s;
      int d;
      bit wr;
      s  = muestras[k*AN +: AN];
      d  = $countones(s ^ m_ref[k]);
      wr = escr && !LE && (dir == k);
      for (int c = 0; c < 3; c++) begin
        longint lim;
        longint sum;
        longint din;
        lim = longint'(1) << cw[c];
        din = {32'b0, dato_in};
        if (wr) begin
          m_cnt[c][k] = din % lim;
          m_des[c][k] = 1'b0;
        end else if (habilitar && m_ok) begin
          sum = m_cnt[c][k] + d;
          if (sum >= lim) begin
            m_des[c][k] = 1'b1;
            m_cnt[c][k] = csat[c] ? lim - 1 : sum - lim;
          end else begin
            m_cnt[c][k] = sum;
          end
        end
      end
      if (wr) m_pico[k] = 0;
      else if (habilitar && m_ok && d > m_pico[k]) m_pico[k] = d;
      if (habilitar) m_ref[k] = s;
    end
    m_ok = habilitar;
  endfunction

  task automatic check_all();
    logic [2:0] e[3];
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < NC; k++) e[c][k] = m_des[c][k];
    chk("dout_32", dout0, m_dout[0]);
    chk("dout_sat", dout1, m_dout[1]);
    chk("dout_wrap", dout2, m_dout[2]);
    chk("dv_32", dv0, m_dv);
    chk("dv_sat", dv1, m_dv);
    chk("dv_wrap", dv2, m_dv);
    chk("des_32", des0, e[0]);
    chk("des_sat", des1, e[1]);
    chk("des_wrap", des2, e[2]);
`ifdef PICO_TRANSICIONES_EN
    begin
      logic [NC*PW-1:0] ep;
      for (int k = 0; k < NC; k++) ep[k*PW +: PW] = PW'(m_pico[k]);
      chk("pico_32", pico0, ep);
      chk("pico_sat", pico1, ep);
    end
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(bit hab, bit [7:0] c0, bit [7:0] c1, bit [7:0] c2,
                       bit le, bit es, bit [1:0] d, bit [31:0] din);
    habilitar = hab;
    muestras  = {c2, c1, c0};
    LE        = le;
    escr      = es;
    dir       = d;
    dato_in   = din;
  endtask

  typedef struct {
    bit        hab;
    bit [7:0]  c0;
    bit        le;
    bit        es;
    bit [1:0]  d;
    bit [31:0] din;
    bit [31:0] exp_dout;
    bit        exp_dv;
  } vec_t;

  function automatic vec_t mk(bit hab, bit [7:0] c0, bit le, bit es,
                              bit [1:0] d, bit [31:0] din,
                              bit [31:0] ed, bit ev);
    vec_t v;
    v.hab = hab; v.c0 = c0; v.le = le; v.es = es; v.d = d;
    v.din = din; v.exp_dout = ed; v.exp_dv = ev;
    return v;
  endfunction

  vec_t tbl[21];

  initial begin
    tbl[0]  = mk(0, 8'h00, 1, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 1);
    tbl[2]  = mk(0, 8'h00, 1, 0, 2, 0, 0, 1);
    tbl[3]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 8'h00, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 8'hFF, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 8'h0F, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 8'h0F, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 8'h0F, 1, 0, 0, 0, 12, 1);
    tbl[9]  = mk(1, 8'h0F, 1, 0, 1, 0, 0, 1);
    tbl[10] = mk(0, 8'hF0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 8'hF0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 8'hF0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 8'hF0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 8'hF1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 8'hF1, 1, 0, 0, 0, 13, 1);
    tbl[16] = mk(0, 8'hF1, 1, 0, 3, 0, 0, 1);
    tbl[17] = mk(0, 8'hF1, 0, 1, 3, 55, 0, 0);
    tbl[18] = mk(0, 8'hF1, 1, 0, 0, 0, 13, 1);
    tbl[19] = mk(0, 8'hF1, 1, 0, 1, 0, 0, 1);
    tbl[20] = mk(0, 8'hF1, 1, 0, 2, 0, 0, 1);

    reset_L = 1'b0;
    drive(0, 8'h00, 8'hAA, 8'h00, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("reset_dout", dout0, 0);
    chk("reset_des", des0, 0);
    reset_L = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].hab, tbl[i].c0, 8'hAA, 8'h00,
            tbl[i].le, tbl[i].es, tbl[i].d, tbl[i].din);
      cycle();
      chk($sformatf("tbl%0d_dout", i), dout0, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_dv", i), dv0, tbl[i].exp_dv);
    end
    chk("tbl_des", des0, 3'b000);
`ifdef PICO_TRANSICIONES_EN
    chk("pico_ch0", pico0[PW-1:0], 8);
    chk("pico_ch1", pico0[2*PW-1:PW], 0);
`endif

    // Write beats a same-cycle 5-bit toggle on channel 1.
    drive(1, 8'hF1, 8'hAA, 8'h00, 0, 0, 0, 0);   cycle();
    drive(1, 8'hF1, 8'hB5, 8'h00, 0, 1, 1, 100); cycle();
    drive(0, 8'hF1, 8'hB5, 8'h00, 1, 0, 1, 0);   cycle();
    chk("coll_wr_read", dout0, 100);
    chk("coll_wr_dv", dv0, 1);
    // Same stimulus with LE=1: write dropped, read sees old value.
    drive(1, 8'hF1, 8'hB5, 8'h00, 0, 0, 0, 0);   cycle();
    drive(1, 8'hF1, 8'hAA, 8'h00, 1, 1, 1, 7);   cycle();
    chk("coll_le_read", dout0, 100);
    drive(0, 8'hF1, 8'hAA, 8'h00, 1, 0, 1, 0);   cycle();
    chk("coll_le_after", dout0, 105);

    // Overflow on the 4-bit instances.
    drive(0, 8'hF1, 8'hAA, 8'h00, 0, 1, 0, 14);  cycle();
    drive(1, 8'h00, 8'hAA, 8'h00, 0, 0, 0, 0);   cycle();
    drive(1, 8'hFF, 8'hAA, 8'h00, 0, 0, 0, 0);   cycle();
    drive(0, 8'hFF, 8'hAA, 8'h00, 1, 0, 0, 0);   cycle();
    chk("ovf_32", dout0, 22);
    chk("ovf_sat", dout1, 15);
    chk("ovf_wrap", dout2, 6);
    chk("ovf_des_32", des0[0], 0);
    chk("ovf_des_sat", des1[0], 1);
    chk("ovf_des_wrap", des2[0], 1);
    drive(0, 8'hFF, 8'hAA, 8'h00, 0, 1, 0, 0);   cycle();
    chk("clr_des_sat", des1[0], 0);
    chk("clr_des_wrap", des2[0], 0);

    // Reset during a read request.
    drive(0, 8'hFF, 8'hAA, 8'h00, 1, 0, 0, 0);
    reset_L = 1'b0;
    cycle();
    chk("rst_mid_dv", dv0, 0);
    chk("rst_mid_dout", dout0, 0);
    reset_L = 1'b1;
    drive(0, 8'hFF, 8'hAA, 8'h00, 0, 0, 0, 0);   cycle();
    chk("rst_mid_idle_dv", dv0, 0);

    for (int i = 0; i < 600; i++) begin
      reset_L   = ($urandom_range(0, 149) != 0);
      habilitar = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        muestras = NC*AN'($urandom);
      else
        muestras = muestras ^ (NC*AN'(1) << $urandom_range(0, NC*AN-1));
      LE   = ($urandom_range(0, 2) == 0);
      escr = ($urandom_range(0, 3) == 0);
      dir  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       dato_in = $urandom;
        1:       dato_in = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: dato_in = 32'($urandom_range(0, 15));
      endcase
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
